jk_count_ctrl: RTL and testbench

JK_COUNT_CTRL -- requirements
Module: jk_count_ctrl

---
 rtl/jk_count_ctrl.sv | 132 +++++++++++++
 tb/tb_jk_count_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: modulo-N up/down counter that steers an external 4-bit JK
// flip-flop bank. It keeps a shadow copy of the bank state, drives per-bit
// J/K from the shadow and its next value, and flags any feedback mismatch.
module jk_count_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic [3:0] mod_n,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    input  logic [3:0] q_fb,
    output logic [3:0] j,
    output logic [3:0] k,
    output logic [3:0] count,
    output logic       tc,
    output logic       err
);

    localparam int unsigned W  = 4;
    localparam int unsigned NW = W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   target;
    logic [W-1:0]   target_nxt;
    logic [W-1:0]   nxt;
    logic [W-1:0]   step;
    logic [W-1:0]   load_tgt;
    logic [NW-1:0]  n_eff;
    logic [W-1:0]   n_m1;
    logic           over;
    logic           accept;

    // Effective modulus (0 encodes 16), its top value, and out-of-range flag.
    always_comb begin
        n_eff = (mod_n == '0) ? NW'(16) : NW'(mod_n);
        n_m1  = W'(n_eff - NW'(1));
        over  = (NW'(count) >= n_eff);
    end

    // Single counting step in the current direction, wrapping at the modulus.
    always_comb begin
        step = '0;
        if (over) begin
            step = '0;
        end else if (up) begin
            step = (count == n_m1) ? '0 : W'(count + W'(1));
        end else begin
            step = (count == '0) ? n_m1 : W'(count - W'(1));
        end
    end

    // Load handshake and the clamped load target.
    always_comb begin
        load_ready = (state != LOAD);
        accept     = load_valid && load_ready;
        load_tgt   = (NW'(load_data) >= n_eff) ? '0 : load_data;
    end

    // Next-state, next-count and target capture; a load beats counting.
    always_comb begin
        state_nxt  = state;
        nxt        = count;
        target_nxt = target;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = LOAD;
                    target_nxt = load_tgt;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    state_nxt  = LOAD;
                    target_nxt = load_tgt;
                end else begin
                    nxt = step;
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end
            end
            LOAD: begin
                nxt       = target;
                state_nxt = en ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // JK excitation: set bits that rise, reset bits that fall, never both.
    always_comb begin
        j  = nxt & ~count;
        k  = count & ~nxt;
        tc = (state == RUN) && (up ? (count == n_m1) : (count == '0));
    end

    // State, shadow count and captured target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            target <= '0;
        end else begin
            state  <= state_nxt;
            count  <= nxt;
            target <= target_nxt;
        end
    end

    // Sticky flag for bank feedback disagreeing with the shadow count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (q_fb != count) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl with a behavioural JK flip-flop bank.
module tb_jk_count_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic [3:0] mod_n;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] count;
    logic       tc;
    logic       err;

    logic [3:0] qb;
    logic [3:0] flip;

    int checks = 0;
    int errors = 0;

    jk_count_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .mod_n      (mod_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .count      (count),
        .tc         (tc),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External JK bank sharing clk/rst; flip injects feedback corruption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qb <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                case ({j[b], k[b]})
                    2'b10:   qb[b] <= 1'b1;
                    2'b01:   qb[b] <= 1'b0;
                    2'b11:   qb[b] <= ~qb[b];
                    default: qb[b] <= qb[b];
                endcase
            end
        end
    end
    assign q_fb = qb ^ flip;

    // J and K must never both be high on any bit.
    always @(negedge clk) begin
        checks++;
        assert ((j & k) === 4'b0000) else begin
            errors++;
            $error("FAIL jk_both: observed j=%b k=%b expected j&k=0000", j, k);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then let outputs settle before driving/checking.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        up         = 1'b1;
        mod_n      = 4'd10;
        load_valid = 1'b0;
        load_data  = 4'd0;
        flip       = 4'b0000;

        // Reset state
        tick();
        tick();
        chk("rst_count", 8'(count), 8'h0);
        chk("rst_j", 8'(j), 8'h0);
        chk("rst_k", 8'(k), 8'h0);
        chk("rst_tc", 8'(tc), 8'h0);
        chk("rst_ready", 8'(load_ready), 8'h1);
        chk("rst_err", 8'(err), 8'h0);
        rst = 1'b0;

        // Idle for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_count", 8'(count), 8'h0);
            chk("idle_jk", 8'({j, k}), 8'h00);
            chk("idle_tc", 8'(tc), 8'h0);
            chk("idle_err", 8'(err), 8'h0);
        end

        // Up wrap, modulus 10: first edge enters RUN with count held
        en = 1'b1;
        #1;
        chk("idle_en_jk", 8'({j, k}), 8'h00);
        tick();
        chk("run0_count", 8'(count), 8'h0);
        chk("run0_j", 8'(j), 8'h1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("up_count", 8'(count), 8'(i));
        end
        chk("up9_tc", 8'(tc), 8'h1);
        chk("up9_j", 8'(j), 8'b0000);
        chk("up9_k", 8'(k), 8'b1001);
        tick();
        chk("upwrap_count", 8'(count), 8'h0);
        chk("upwrap_tc", 8'(tc), 8'h0);

        // Down wrap, modulus 5, direction change takes effect same cycle
        mod_n = 4'd5;
        up    = 1'b0;
        #1;
        chk("dn0_tc", 8'(tc), 8'h1);
        chk("dn0_j", 8'(j), 8'b0100);
        chk("dn0_k", 8'(k), 8'b0000);
        tick();
        chk("dnwrap_count", 8'(count), 8'h4);
        chk("dnwrap_tc", 8'(tc), 8'h0);
        tick();
        chk("dn3_count", 8'(count), 8'h3);

        // Load 12 during RUN with modulus 16
        mod_n      = 4'd0;
        load_valid = 1'b1;
        load_data  = 4'd12;
        #1;
        chk("acc_jk", 8'({j, k}), 8'h00);
        chk("acc_ready", 8'(load_ready), 8'h1);
        tick();
        load_valid = 1'b0;
        #1;
        chk("load_count", 8'(count), 8'h3);
        chk("load_ready", 8'(load_ready), 8'h0);
        chk("load_j", 8'(j), 8'b1100);
        chk("load_k", 8'(k), 8'b0011);
        chk("load_tc", 8'(tc), 8'h0);
        tick();
        chk("loaded_count", 8'(count), 8'hc);
        chk("loaded_ready", 8'(load_ready), 8'h1);
        tick();
        chk("run_after_load", 8'(count), 8'hb);

        // Load 12 with modulus 8 clamps the target to 0
        mod_n      = 4'd8;
        load_valid = 1'b1;
        load_data  = 4'd12;
        #1;
        chk("acc2_jk", 8'({j, k}), 8'h00);
        tick();
        load_valid = 1'b0;
        #1;
        chk("load2_ready", 8'(load_ready), 8'h0);
        chk("load2_j", 8'(j), 8'b0000);
        chk("load2_k", 8'(k), 8'b1011);
        tick();
        chk("loaded2_count", 8'(count), 8'h0);
        chk("loaded2_tc", 8'(tc), 8'h1);
        chk("pre_mm_err", 8'(err), 8'h0);

        // Feedback mismatch for one cycle sets sticky err
        flip = 4'b0001;
        tick();
        flip = 4'b0000;
        chk("mm_err", 8'(err), 8'h1);
        tick();
        chk("mm_err_hold1", 8'(err), 8'h1);
        tick();
        chk("mm_err_hold2", 8'(err), 8'h1);

        // Asynchronous reset mid-RUN clears everything at once
        rst = 1'b1;
        #1;
        chk("arst_err", 8'(err), 8'h0);
        chk("arst_count", 8'(count), 8'h0);
        chk("arst_tc", 8'(tc), 8'h0);
        tick();
        rst = 1'b0;

        // Modulus shrink: load 9, then modulus 6 counting down goes to 0
        mod_n      = 4'd0;
        up         = 1'b0;
        en         = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'd9;
        tick();
        load_valid = 1'b0;
        tick();
        chk("shr_count9", 8'(count), 8'h9);
        mod_n = 4'd6;
        #1;
        chk("shr_j", 8'(j), 8'b0000);
        chk("shr_k", 8'(k), 8'b1001);
        tick();
        chk("shr_count0", 8'(count), 8'h0);
        chk("shr_err", 8'(err), 8'h0);

        // Reset asserted mid-LOAD aborts the load
        load_valid = 1'b1;
        load_data  = 4'd5;
        tick();
        load_valid = 1'b0;
        en         = 1'b0;
        #1;
        chk("midload_ready", 8'(load_ready), 8'h0);
        rst = 1'b1;
        #1;
        chk("abort_ready", 8'(load_ready), 8'h1);
        chk("abort_jk", 8'({j, k}), 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_count", 8'(count), 8'h0);
        tick();
        chk("abort_count2", 8'(count), 8'h0);
        chk("abort_err", 8'(err), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
